// File: rtl/bp_rom_pkg.sv
// Shared constants for the BankPanic ROM download path: region map and FSM states.
// Byte addresses are 17 bits wide, which covers the highest region (PROMs at 0x10000).
// Regions are listed in priority order; they do not overlap.
package bp_rom_pkg;

  localparam int NUM_REGIONS = 4;
  localparam int BYTE_AW     = 17;

  typedef logic [BYTE_AW-1:0] byte_addr_t;

  // 0 main CPU, 1 tiles, 2 sprites, 3 PROMs
  localparam byte_addr_t REGION_BASE [NUM_REGIONS] = '{17'h00000, 17'h08000, 17'h0C000, 17'h10000};
  localparam byte_addr_t REGION_SIZE [NUM_REGIONS] = '{17'h08000, 17'h04000, 17'h04000, 17'h00120};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } dl_state_t;

endpackage

// File: rtl/rom_region_decode.sv
// Maps a download byte address onto one of the ROM regions.
// Purely combinational, zero latency.
// No flow control; a miss reports hit = 0 with sel and local_addr at 0.
module rom_region_decode
  import bp_rom_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic [BYTE_AW-1:0]     byte_addr,
  output logic                   hit,
  output logic [NUM_REGIONS-1:0] sel,
  output logic [ADDR_W-1:0]      local_addr
);

  // First region whose [base, base+size) window contains the address wins
  always_comb begin
    hit        = 1'b0;
    sel        = '0;
    local_addr = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit && (byte_addr >= REGION_BASE[i]) &&
          (byte_addr < (REGION_BASE[i] + REGION_SIZE[i]))) begin
        hit        = 1'b1;
        sel[i]     = 1'b1;
        local_addr = ADDR_W'(byte_addr - REGION_BASE[i]);
      end
    end
  end

endmodule

// File: rtl/rom_download_ctrl.sv
// Splits hps_io 16-bit download words into two region-decoded ROM byte writes.
// Latency: ioctl_wr to even byte strobe 2 cycles, odd byte 3 cycles (mem_ready high).
// Backpressure: ioctl_wait held while a word is pending; bytes wait for mem_ready.
module rom_download_ctrl
  import bp_rom_pkg::*;
#(
  parameter int         ADDR_W     = 15,
  parameter logic [7:0] GAME_INDEX = 8'd0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [26:0]            ioctl_addr,
  input  logic [15:0]            ioctl_dout,
  output logic                   ioctl_wait,
  input  logic                   mem_ready,
  output logic                   rom_we,
  output logic [NUM_REGIONS-1:0] rom_sel,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic                   dl_busy,
  output logic                   dl_done,
  output logic                   dl_err
);

  dl_state_t              state_q, state_d;
  byte_addr_t             word_addr_q, word_addr_d;
  logic [15:0]            word_dat_q, word_dat_d;
  logic                   ioctl_wait_q, ioctl_wait_d;
  logic                   rom_we_q, rom_we_d;
  logic [NUM_REGIONS-1:0] rom_sel_q, rom_sel_d;
  logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
  logic [7:0]             rom_data_q, rom_data_d;
  logic                   dl_busy_q, dl_busy_d;
  logic                   dl_done_q, dl_done_d;
  logic                   dl_err_q, dl_err_d;
  logic                   act_q;

  logic                   act;
  logic                   act_rise;
  logic                   wr_err;
  logic                   byte_err;
  byte_addr_t             byte_addr;
  logic                   byte_hit;
  logic [NUM_REGIONS-1:0] byte_sel;
  logic [ADDR_W-1:0]      byte_local;
  logic [7:0]             byte_dat;
  logic                   unused_addr_bits;

  // Only bits [16:1] of the word address reach the region map
  assign unused_addr_bits = ^{ioctl_addr[26:17], ioctl_addr[0]};

  assign act      = ioctl_download && (ioctl_index == GAME_INDEX);
  assign act_rise = act && !act_q;

  // Even byte in LO, odd byte in HI; each is decoded on its own
  assign byte_addr = (state_q == HI) ? {word_addr_q[BYTE_AW-1:1], 1'b1} : word_addr_q;
  assign byte_dat  = (state_q == HI) ? word_dat_q[15:8] : word_dat_q[7:0];

  rom_region_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .byte_addr  (byte_addr),
    .hit        (byte_hit),
    .sel        (byte_sel),
    .local_addr (byte_local)
  );

  // Word FSM: accept a word, then emit even and odd bytes as mem_ready allows
  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    word_dat_d  = word_dat_q;
    rom_we_d    = 1'b0;
    rom_sel_d   = '0;
    rom_addr_d  = '0;
    rom_data_d  = '0;
    wr_err      = 1'b0;
    byte_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ioctl_wr && act) begin
          word_addr_d = {ioctl_addr[16:1], 1'b0};
          word_dat_d  = ioctl_dout;
          state_d     = LO;
        end
      end
      LO, HI: begin
        // A new word while one is pending is dropped; the pending one is kept
        wr_err = ioctl_wr && act;
        if (mem_ready) begin
          rom_we_d   = byte_hit;
          rom_sel_d  = byte_sel;
          rom_addr_d = byte_hit ? byte_local : '0;
          rom_data_d = byte_hit ? byte_dat : 8'h00;
          byte_err   = !byte_hit;
          state_d    = (state_q == LO) ? HI : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Stall stays up through the cycle the odd byte strobes
    ioctl_wait_d = (state_q != IDLE) || (state_d != IDLE);
  end

  // Download envelope: busy from act rising until act low with no word pending
  always_comb begin
    dl_busy_d = dl_busy_q;
    dl_done_d = 1'b0;
    dl_err_d  = act_rise ? 1'b0 : dl_err_q;
    if (wr_err || byte_err) begin
      dl_err_d = 1'b1;
    end
    if (act_rise) begin
      dl_busy_d = 1'b1;
    end else if (dl_busy_q && !act && (state_q == IDLE)) begin
      dl_busy_d = 1'b0;
      dl_done_d = 1'b1;
    end
  end

  // State and output registers; reset discards any pending word
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      word_addr_q  <= '0;
      word_dat_q   <= '0;
      ioctl_wait_q <= 1'b0;
      rom_we_q     <= 1'b0;
      rom_sel_q    <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      dl_busy_q    <= 1'b0;
      dl_done_q    <= 1'b0;
      dl_err_q     <= 1'b0;
      act_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      word_dat_q   <= word_dat_d;
      ioctl_wait_q <= ioctl_wait_d;
      rom_we_q     <= rom_we_d;
      rom_sel_q    <= rom_sel_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      dl_busy_q    <= dl_busy_d;
      dl_done_q    <= dl_done_d;
      dl_err_q     <= dl_err_d;
      act_q        <= act;
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign rom_we     = rom_we_q;
  assign rom_sel    = rom_sel_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign dl_busy    = dl_busy_q;
  assign dl_done    = dl_done_q;
  assign dl_err     = dl_err_q;

endmodule
